pipe_wb_regfile: RTL



---
 rtl/pipe_wb_regfile_pkg.sv | 30 +++
 rtl/pipe_wb_regfile_mux.sv | 24 ++
 rtl/pipe_wb_regfile.sv | 102 ++++++++++
 3 files changed

// File: rtl/pipe_wb_regfile_pkg.sv
// Shared definitions for the writeback stage and general-purpose register file.
// Provides datapath/address widths, the register-number type, the hardwired
// zero register number, and the MEM/WB writeback bundle type.
package pipe_wb_regfile_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned REG_NUM = 2 ** REG_AW;

  typedef logic [REG_AW-1:0] reg_num_t;
  typedef logic [DATA_W-1:0] word_t;

  // Register 0 always reads as zero and is never written.
  localparam reg_num_t REG_ZERO = 5'd0;

  // MEM/WB register payload as seen by the writeback stage.
  typedef struct packed {
    logic     wreg;
    logic     reg2reg;
    word_t    alur;
    word_t    dout;
    reg_num_t rd;
  } wb_bus_t;

  // True when a register number addresses the hardwired zero register.
  function automatic logic is_zero_reg(input reg_num_t r);
    return r == REG_ZERO;
  endfunction

endpackage

// File: rtl/pipe_wb_regfile_mux.sv
// pipe_wb_mux: 2:1 writeback source selector.
// Ports:
//   sel       - 1 selects load data, 0 selects ALU result
//   alu_res   - registered ALU result
//   load_data - registered data-memory read data
//   wb_data   - selected writeback value (combinational)
module pipe_wb_mux #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] wb_data
);

  // Pure select; no state, always driven.
  always_comb begin
    wb_data = alu_res;
    if (sel) begin
      wb_data = load_data;
    end
  end

endmodule

// File: rtl/pipe_wb_regfile.sv
// pipe_wb_regfile: writeback stage plus 32 x 32-bit general-purpose register file.
// Selects the writeback value from the MEM/WB register, commits it on the rising
// clock edge, and serves two combinational decode-stage read ports.
// Optional macro PIPE_WB_BYPASS_EN: when defined, a read of the register being
// written this cycle returns the writeback value instead of the stored one.
// Ports:
//   Clk, Clrn          - clock, asynchronous active-low reset
//   W_Wreg, W_Reg2reg  - writeback enable, source select (1 = load data)
//   W_ALUR, W_Dout     - ALU result, load data
//   W_Rd               - destination register number
//   Rs, Rt / Qa, Qb    - read port addresses / data
//   W_Data             - selected writeback value, for EX-stage forwarding
module pipe_wb_regfile #(
  parameter int unsigned DATA_W = pipe_wb_regfile_pkg::DATA_W,
  parameter int unsigned REG_AW = pipe_wb_regfile_pkg::REG_AW
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic              W_Wreg,
  input  logic              W_Reg2reg,
  input  logic [DATA_W-1:0] W_ALUR,
  input  logic [DATA_W-1:0] W_Dout,
  input  logic [REG_AW-1:0] W_Rd,
  input  logic [REG_AW-1:0] Rs,
  input  logic [REG_AW-1:0] Rt,
  output logic [DATA_W-1:0] Qa,
  output logic [DATA_W-1:0] Qb,
  output logic [DATA_W-1:0] W_Data
);

  import pipe_wb_regfile_pkg::*;

  localparam int unsigned       NREG    = 2 ** REG_AW;
  localparam logic [REG_AW-1:0] RD_ZERO = REG_AW'(REG_ZERO);

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_en_c;
  logic [DATA_W-1:0] rd_a_c;
  logic [DATA_W-1:0] rd_b_c;

  // Writeback source select; shared by commit and bypass paths.
  pipe_wb_mux #(
    .DATA_W (DATA_W)
  ) u_wb_mux (
    .sel       (W_Reg2reg),
    .alu_res   (W_ALUR),
    .load_data (W_Dout),
    .wb_data   (W_Data)
  );

  // Writes to register 0 are dropped here, so it keeps its reset value of zero.
  assign wr_en_c = W_Wreg && (W_Rd != RD_ZERO);

  // Register array: reset clears every entry, commit on rising edge.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en_c) begin
      regs[W_Rd] <= W_Data;
    end
  end

  // Stored-value read ports; address 0 forced to zero independent of storage.
  always_comb begin
    rd_a_c = '0;
    rd_b_c = '0;
    if (Rs != RD_ZERO) begin
      rd_a_c = regs[Rs];
    end
    if (Rt != RD_ZERO) begin
      rd_b_c = regs[Rt];
    end
  end

`ifdef PIPE_WB_BYPASS_EN
  logic byp_a_c;
  logic byp_b_c;

  // Bypass only when the write will actually commit: gated off during reset,
  // and wr_en_c already excludes register 0.
  assign byp_a_c = wr_en_c && Clrn && (Rs == W_Rd);
  assign byp_b_c = wr_en_c && Clrn && (Rt == W_Rd);

  always_comb begin
    Qa = rd_a_c;
    Qb = rd_b_c;
    if (byp_a_c) begin
      Qa = W_Data;
    end
    if (byp_b_c) begin
      Qb = W_Data;
    end
  end
`else
  // No bypass: decode sees the old value in the commit cycle.
  assign Qa = rd_a_c;
  assign Qb = rd_b_c;
`endif

endmodule
